uart_tx_fifo: RTL and testbench

Buffered UART transmitter that sends bytes produced on-chip (CPU store or loopback logic) out on the serial TX line. It is the transmit-direction companion to the existing receive path. A small synchronous FIFO decouples byte writes from line timing. An internal baud counter removes the need for an external bps_module. Frame format is 8N1, LSB first, with an optional parity bit.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum, line levels and frame constants.
// Reused by the TX path here and by the future RX rewrite.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Pushes are refused when full and pops are ignored when empty.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with internal baud counter and FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          ovf,
    output logic                          tx_pin_out
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_e        state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_dout;
    logic               bit_done;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign bit_done   = (baud_q == BAUD_LAST);
    assign tx_pin_out = tx_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_done ? 16'd0 : baud_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next frame so back-to-back bytes leave no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_dout);
`endif
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) baud_d = '0;

        // The line level is registered from the next state so tx_pin_out is a pure flop output.
        unique case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase

        busy_d = (state_d != IDLE);

        ovf_d = ovf_q;
        if (clr_ovf)        ovf_d = 1'b0;
        if (wr_en && full)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based line model compared every cycle,
// plus directed vectors with hand-computed line levels and flag values.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit [0:NBITS-1] A5_LINE = 11'b01010010101;
`else
    localparam int NBITS = 10;
    localparam bit [0:NBITS-1] A5_LINE = 10'b0101001011;
`endif
    localparam int FRAME = NBITS * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       full;
    logic [2:0] fifo_count;
    logic       busy;
    logic       ovf;
    logic       tx_pin_out;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .full       (full),
        .fifo_count (fifo_count),
        .busy       (busy),
        .ovf        (ovf),
        .tx_pin_out (tx_pin_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: bytes waiting in the FIFO, and the exact line levels still to be driven.
    bit [7:0] data_q [$];
    bit       wave_q [$];
    bit       m_ovf;

    function automatic void push_frame(input bit [7:0] b);
        bit bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int j = 0; j < C; j++) wave_q.push_back(bits[i]);
    endfunction

    function automatic void model_reset();
        data_q.delete();
        wave_q.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step();
        bit can_pop;
        bit acc;
        can_pop = (data_q.size() > 0) && (wave_q.size() <= 1);
        acc     = wr_en && (data_q.size() < DEPTH);
        if (wave_q.size() > 0) void'(wave_q.pop_front());
        if (can_pop) push_frame(data_q.pop_front());
        if (acc) data_q.push_back(wr_data);
        if (wr_en && !acc) m_ovf = 1'b1;
        else if (clr_ovf)  m_ovf = 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("tx_line",    tx_pin_out, (wave_q.size() > 0) ? wave_q[0] : 1'b1);
            check("busy",       busy,       wave_q.size() > 0);
            check("fifo_count", fifo_count, data_q.size());
            check("full",       full,       data_q.size() == DEPTH);
            check("ovf",        ovf,        m_ovf);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || fifo_count != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_wait", n < budget, 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        step(3);
        check("rst_tx",    tx_pin_out, 1);
        check("rst_busy",  busy,       0);
        check("rst_full",  full,       0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf",   ovf,        0);
        rst    = 1'b0;
        chk_en = 1'b1;
        step(5);

        // Single byte 0xA5: line falls two cycles after the write, then the hand-derived frame.
        write(8'hA5);
        check("a5_count_n1", fifo_count, 1);
        check("a5_tx_n1",    tx_pin_out, 1);
        step();
        for (int i = 0; i < NBITS; i++) begin
            for (int j = 0; j < C; j++) begin
                check("a5_line", tx_pin_out, A5_LINE[i]);
                if (i == NBITS - 1 && j == C - 1) check("a5_busy_last", busy, 1);
                step();
            end
        end
        check("a5_busy_fall", busy, 0);
        check("a5_tx_idle",   tx_pin_out, 1);
        step(3);

        // Burst of three: frames abut, FIFO drains to zero at the third pop.
        write(8'h00);
        write(8'hFF);
        write(8'h55);
        check("burst_count_k3", fifo_count, 2);
        step(FRAME - 2);
        check("burst_f1_stop",  tx_pin_out, 1);
        step();
        check("burst_f2_start", tx_pin_out, 0);
        check("burst_count_f2", fifo_count, 1);
        step(FRAME - 1);
        check("burst_f2_stop",  tx_pin_out, 1);
        check("burst_count_b3", fifo_count, 1);
        step();
        check("burst_f3_start", tx_pin_out, 0);
        check("burst_count_f3", fifo_count, 0);
        check("burst_busy_f3",  busy, 1);
        wait_idle(400);
        step(2);

        // Overflow: one byte in the shifter, four queued, sixth write refused.
        write(8'h11);
        write(8'h22);
        write(8'h33);
        write(8'h44);
        write(8'h55);
        write(8'h66);
        check("ovf_full",  full,       1);
        check("ovf_count", fifo_count, 4);
        check("ovf_set",   ovf,        1);
        step(2);
        check("ovf_sticky", ovf, 1);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        clr_ovf = 1'b1;
        step();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins",  ovf,        1);
        check("ovf_count_hld", fifo_count, 4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf,  0);
        check("ovf_full2",   full, 1);
        wait_idle(1000);
        step(2);

        // Reset during data bit 4 of 0x0F (a low bit) with two more bytes queued.
        write(8'h0F);
        write(8'h33);
        write(8'h44);
        step(20);
        check("mid_bit4_low", tx_pin_out, 0);
        check("mid_count",    fifo_count, 2);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_tx",    tx_pin_out, 1);
        check("rst_mid_busy",  busy,       0);
        check("rst_mid_count", fifo_count, 0);
        step(2);
        rst = 1'b0;
        step(2);
        write(8'h81);
        step();
        check("post_rst_start", tx_pin_out, 0);
        step(C);
        check("post_rst_bit0",  tx_pin_out, 1);
        wait_idle(200);
        step(2);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1 and the frame is 44 cycles.
        write(8'h07);
        step(36);
        check("par_bit7",   tx_pin_out, 0);
        step();
        check("par_bit",    tx_pin_out, 1);
        step(C);
        check("par_stop",   tx_pin_out, 1);
        step(C);
        check("par_busy_fall", busy, 0);
        step(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
